// File: rtl/mult_pkg.sv
// Shared definitions for the shared-multiplier arbiter: state encoding and datapath widths.
package mult_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/array_multiplier_4bit.sv
// Combinational 4x4 unsigned array multiplier built from shifted partial products.
module array_multiplier_4bit
  import mult_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] product
);

  logic [PROD_W-1:0] acc [0:OP_W];

  assign acc[0] = '0;

  // Each row adds a gated copy of a, shifted by the row index, into the running sum.
  for (genvar i = 0; i < OP_W; i++) begin : g_row
    logic [OP_W-1:0]   pp;
    logic [PROD_W-1:0] pp_ext;
    assign pp         = a & {OP_W{b[i]}};
    assign pp_ext     = {{(PROD_W-OP_W){1'b0}}, pp} << i;
    assign acc[i + 1] = acc[i] + pp_ext;
  end

  assign product = acc[OP_W];

endmodule

// File: rtl/mult_share_arbiter.sv
// Two requesters share one array multiplier; round-robin grant, fixed settle time, held response.
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [OP_W-1:0]   req_a0,
  input  logic [OP_W-1:0]   req_b0,
  input  logic [OP_W-1:0]   req_a1,
  input  logic [OP_W-1:0]   req_b1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [PROD_W-1:0] rsp_product,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

  state_t            state;
  state_t            state_next;
  logic              last_grant;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic [PROD_W-1:0] mult_out;
  logic [PROD_W-1:0] product_q;
  logic              id_q;
  logic [CNT_W-1:0]  counter;
  logic              any_req;
  logic              grant_id;
  logic              settle_last;

  // Operands come only from registers, so the multiplier inputs are frozen while settling.
  array_multiplier_4bit u_mult (
    .a       (op_a),
    .b       (op_b),
    .product (mult_out)
  );

  // Round-robin pick: on contention the requester that was not served last wins.
  always_comb begin
    any_req  = |req_valid;
    grant_id = 1'b0;
    if (req_valid == 2'b11) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req_valid[1];
    end
  end

  assign settle_last = (counter == LAST_CNT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake strobes; outputs are forced quiet while reset is asserted.
  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          req_ready  = grant_id ? 2'b10 : 2'b01;
          state_next = LOAD;
        end
      end
      LOAD: begin
        state_next = SETTLE;
      end
      SETTLE: begin
        if (settle_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (rst) begin
      req_ready = 2'b00;
    end
  end

  // Datapath registers: capture operands at grant, count settle cycles, sample the product.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      product_q  <= '0;
      id_q       <= 1'b0;
      counter    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            op_a       <= grant_id ? req_a1 : req_a0;
            op_b       <= grant_id ? req_b1 : req_b0;
            id_q       <= grant_id;
            last_grant <= grant_id;
          end
        end
        LOAD: begin
          counter <= '0;
        end
        SETTLE: begin
          if (settle_last) begin
            product_q <= mult_out;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_valid   = (state == DONE) && !rst;
  assign busy        = (state != IDLE) && !rst;
  assign rsp_id      = id_q;
  assign rsp_product = product_q;

endmodule
